// File: rtl/shift_in_if.sv
// Parallel-side bundle of the serial receiver: strobe, serial bit, ack in;
// assembled word, valid, overrun and busy out.
interface shift_in_if #(
  parameter int WIDTH = 8
) ();
  logic             ena;
  logic             data_in;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output ena, data_in, data_ack,
    input  data_out, data_valid, overrun, busy
  );

  modport slave (
    input  ena, data_in, data_ack,
    output data_out, data_valid, overrun, busy
  );
endinterface

// File: rtl/shift_in.sv
// LSB-first serial-to-parallel receiver with valid/ack handshake and sticky
// overrun flag. Word framing is fixed by reset alone.
module shift_in #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  shift_in_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  assign shifted  = {bus.data_in, sr_q[WIDTH-1:1]};
  assign complete = bus.ena && (cnt_q == LAST);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;

    if (bus.ena) begin
      sr_d  = shifted;
      cnt_d = cnt_q + CW'(1);
    end

    if (complete) begin
      cnt_d        = '0;
      data_out_d   = shifted;
      data_valid_d = 1'b1;
      // A coincident ack consumes the old word, so only an un-acked one overflows.
      if (data_valid_q && !bus.data_ack) overrun_d = 1'b1;
    end else if (data_valid_q && bus.data_ack) begin
      data_valid_d = 1'b0;
    end
  end

  // NOTE: reset is sampled on the clock edge only (synchronous, active-low),
  // and all state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (cnt_q != '0);
endmodule

// File: tb/tb_shift_in.sv
// Directed bench for shift_in: a bit-list word model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_shift_in;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_in_if #(.WIDTH(W)) bus_i ();

  shift_in #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word model: collect sampled bits by position, publish when W have arrived.
  int           nbits;
  logic [W-1:0] acc;
  logic [W-1:0] exp_out;
  logic         exp_valid;
  logic         exp_ovr;
  bit           model_ok = 1'b0;
  bit           done;

  always @(posedge clk) begin
    done = 1'b0;
    if (rst === 1'b0) begin
      nbits     = 0;
      acc       = '0;
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (bus_i.ena) begin
        acc[nbits] = bus_i.data_in;
        nbits++;
        done = (nbits == W);
      end
      if (done) begin
        if (exp_valid && !bus_i.data_ack) exp_ovr = 1'b1;
        exp_out   = acc;
        exp_valid = 1'b1;
        nbits     = 0;
        acc       = '0;
      end else if (exp_valid && bus_i.data_ack) begin
        exp_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      check("cyc data_out",   32'(bus_i.data_out),   32'(exp_out));
      check("cyc data_valid", 32'(bus_i.data_valid), 32'(exp_valid));
      check("cyc overrun",    32'(bus_i.overrun),    32'(exp_ovr));
      check("cyc busy",       32'(bus_i.busy),       32'(nbits != 0));
    end
  end

  // Entered at a falling edge; inputs apply to the next rising edge.
  task automatic tick(input logic e, input logic d, input logic a);
    bus_i.ena      = e;
    bus_i.data_in  = d;
    bus_i.data_ack = a;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ack_last);
    for (int i = 0; i < W; i++) tick(1'b1, w[i], ack_last && (i == W - 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a5_bits;
    rst            = 1'b0;
    bus_i.ena      = 1'b0;
    bus_i.data_in  = 1'b0;
    bus_i.data_ack = 1'b0;
    @(negedge clk);

    // Reset held with strobe active and data toggling.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, i[0], 1'b0);
      check("rst data_out",   32'(bus_i.data_out),   32'h00);
      check("rst data_valid", 32'(bus_i.data_valid), 32'h0);
      check("rst overrun",    32'(bus_i.overrun),    32'h0);
      check("rst busy",       32'(bus_i.busy),       32'h0);
    end
    rst = 1'b1;

    // Back-to-back 0xA5: bits 1,0,1,0,0,1,0,1.
    a5_bits = 8'hA5;
    for (int i = 0; i < W; i++) begin
      tick(1'b1, a5_bits[i], 1'b0);
      if (i < W - 1) check("b2b busy mid", 32'(bus_i.busy), 32'h1);
    end
    check("b2b data_out",   32'(bus_i.data_out),   32'hA5);
    check("b2b data_valid", 32'(bus_i.data_valid), 32'h1);
    check("b2b busy end",   32'(bus_i.busy),       32'h0);
    check("model pins A5",  32'(exp_out),          32'hA5);

    tick(1'b0, 1'b0, 1'b1);
    check("ack A5 valid", 32'(bus_i.data_valid), 32'h0);

    // Gapped strobe carrying 0x3C, inverted data on idle cycles.
    for (int i = 0; i < W; i++) begin
      tick(1'b1, a5_bits[0] ^ a5_bits[0] ^ 8'h3C >> i, 1'b0);
      tick(1'b0, ~(8'h3C >> i), 1'b0);
      if (i < W - 1) check("gap data_out held", 32'(bus_i.data_out), 32'hA5);
      tick(1'b0, ~(8'h3C >> i), 1'b0);
    end
    check("gap data_out",   32'(bus_i.data_out),   32'h3C);
    check("gap data_valid", 32'(bus_i.data_valid), 32'h1);
    check("gap overrun",    32'(bus_i.overrun),    32'h0);

    // Handshake: valid rose two edges ago; ack now.
    tick(1'b0, 1'b0, 1'b1);
    check("hs valid cleared", 32'(bus_i.data_valid), 32'h0);
    check("hs data_out held", 32'(bus_i.data_out),   32'h3C);
    tick(1'b0, 1'b0, 1'b1);
    check("hs idle ack valid", 32'(bus_i.data_valid), 32'h0);
    check("hs idle ack out",   32'(bus_i.data_out),   32'h3C);

    // Overrun: two words without ack.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("ovr data_out", 32'(bus_i.data_out), 32'h22);
    check("ovr overrun",  32'(bus_i.overrun),  32'h1);
    check("model pins ovr", 32'(exp_ovr), 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    check("ovr ack valid",   32'(bus_i.data_valid), 32'h0);
    check("ovr sticky",      32'(bus_i.overrun),    32'h1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("ovr still sticky", 32'(bus_i.overrun), 32'h1);

    // Fresh reset, then coincident ack on the second completion.
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    check("rst2 overrun", 32'(bus_i.overrun), 32'h0);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b1);
    check("coin data_valid", 32'(bus_i.data_valid), 32'h1);
    check("coin data_out",   32'(bus_i.data_out),   32'h22);
    check("coin overrun",    32'(bus_i.overrun),    32'h0);

    // Mid-word reset discards partial bits.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("mid busy", 32'(bus_i.busy), 32'h1);
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    check("mid rst busy", 32'(bus_i.busy), 32'h0);
    send_word(8'hF0, 1'b0);
    check("mid data_out",   32'(bus_i.data_out),   32'hF0);
    check("mid data_valid", 32'(bus_i.data_valid), 32'h1);
    check("mid overrun",    32'(bus_i.overrun),    32'h0);
    check("model pins F0",  32'(exp_out),          32'hF0);

    tick(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shift_in.md
# shift_in

Serial-to-parallel receiver: the receiving end of the team's LSB-first, strobe-qualified serial link driven by the byte serializer. It samples one bit of `data_in` per clock in which `ena` is high and assembles WIDTH bits into a word. It presents the word with a valid/ack handshake and flags overrun when a word is overwritten before it was consumed. It sits between the serial pin/loopback path and the parallel consumer logic.

## Interface
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `ena`  in  1  sample strobe; `data_in` is sampled only on edges where `ena`=1.
- `data_in`  in  1  serial bit; first sampled bit is the LSB.
- `data_ack`  in  1  consumer acknowledge; effective only while `data_valid`=1.
- `data_out`  out  WIDTH  last completed word (registered).
- `data_valid`  out  1  high from word completion until acked.
- `overrun`  out  1  sticky; set when a completed word overwrites an un-acked word.
- `busy`  out  1  high while a partial word (1..WIDTH-1 bits) is held.

## Operation
- State: shift register `sr[WIDTH-1:0]`, bit counter `cnt` (0..WIDTH-1, width clog2(WIDTH)), and output registers.
- Reset (`rst`=0 at an edge) overrides everything: `sr`=0, `cnt`=0, `data_out`=0, `data_valid`=0, `overrun`=0, `busy`=0. Partial bits are discarded.
- Sample edge (`ena`=1, `cnt` < WIDTH-1): `sr` <= {`data_in`, `sr[WIDTH-1:1]`} (shift right, new bit enters the MSB) and `cnt` <= `cnt`+1.
- Completion edge (`ena`=1, `cnt`=WIDTH-1):
  - `data_out` <= {`data_in`, `sr[WIDTH-1:1]`}, so the first sampled bit lands in bit 0.
  - `data_valid` <= 1 and `cnt` <= 0.
- Non-`ena` edges leave `sr` and `cnt` unchanged; `data_in` is ignored.
- Handshake:
  - `data_valid`=1 and `data_ack`=1 at an edge with no completion clears `data_valid`.
  - `data_ack` while `data_valid`=0 is ignored.
  - `data_out` holds its value until the next completion, including after ack.
- Simultaneous completion and ack on the same edge: the ack consumes the old word, the new word loads, `data_valid` stays 1, and `overrun` is not set.
- Overrun: completion while `data_valid`=1 and `data_ack`=0 sets `overrun`. The newest word wins and `data_out` is overwritten. Only reset clears `overrun`.
- `busy` = (`cnt` != 0), driven combinationally from the registered `cnt`.
- The word counter wraps continuously, so back-to-back words need no idle gap.

## Timing
- Word latency: `data_out` and `data_valid` update on the same edge that samples the WIDTH-th bit, i.e. visible 1 clk after that bit is presented.
- `ena` may be high every cycle; one word per WIDTH clocks maximum throughput.
- `data_valid` falls on the edge where `data_ack` is sampled high (unless a completion coincides).
- Alignment: word framing is established solely by reset.
  - The serializer updates its output on its own `ena` edge.
  - The integrating level therefore drives this block's `ena` one clk after the serializer's `ena`, so each bit is stable when sampled.
- Reset mid-word: the next `ena` after reset release samples bit 0 of a new word.

## Test plan
- Reset: hold `rst`=0 for 3 clk with `ena`=1 and `data_in` toggling → `data_out`=0x00, `data_valid`=0, `overrun`=0, `busy`=0 throughout.
- Back-to-back: `ena`=1 for 8 clk with bits 1,0,1,0,0,1,0,1 → `data_out`=0xA5 and `data_valid`=1 after the 8th edge; `busy`=1 after edges 1–7, 0 after edge 8.
- Gapped strobe: `ena` every 3rd clk carrying 0x3C LSB-first, with `data_in` inverted on non-`ena` cycles → `data_out`=0x3C; no change on non-`ena` edges.
- Handshake:
  - `data_ack` 2 clk after `data_valid` rises → `data_valid`=0 next edge, `data_out` still 0x3C.
  - `data_ack` with `data_valid`=0 → no effect.
- Overrun and coincident ack:
  - Send 0x11 then 0x22 without ack → `data_out`=0x22, `overrun`=1; ack clears `data_valid` but `overrun` stays 1 until reset.
  - After a fresh reset, send 0x11 then 0x22 with `data_ack` high exactly on 0x22's completion edge → `data_valid`=1, `data_out`=0x22, `overrun`=0.
- Mid-word reset: send 4 bits, pulse `rst`=0 for 1 clk, then send 0xF0 → `data_out`=0xF0, `overrun`=0.
